ifu_fetch_queue: RTL and testbench

Multi-cycle instruction fetch front end that feeds decode. Replaces a direct combinational PC-to-instruction read with a request/response instruction-memory interface. Issues sequential fetches and buffers returned {pc, inst} pairs in a small in-order queue for the decode stage (valid/ready). A redirect from execute (branch/jump dnpc) flushes the queue and discards stale in-flight responses.

---
 rtl/ifu_fetch_queue_pkg.sv | 17 +
 rtl/ifu_fetch_queue_chk.sv | 14 +
 rtl/ifu_inst_fifo.sv | 66 ++++++
 rtl/ifu_fetch_queue.sv | 113 +++++++++++
 tb/tb_ifu_fetch_queue.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifu_fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_chk.sv
// Protocol checks for the instruction memory response channel.
module ifu_fetch_queue_chk #(
  parameter int IW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_rsp_valid,
  input logic [IW-1:0] inflight
);

  rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (inflight == {IW{1'b0}})));

endmodule

// File: rtl/ifu_inst_fifo.sv
// In-order {pc, inst} queue between fetch and decode; flush wins over push.
module ifu_inst_fifo
  import ifu_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [XLEN-1:0]        push_pc,
  input  logic [XLEN-1:0]        push_inst,
  output logic [XLEN-1:0]        head_pc,
  output logic [XLEN-1:0]        head_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t     mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          empty_s;
  logic          do_pop_s;
  logic          do_push_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign do_pop_s  = pop && !empty_s;
  assign do_push_s = push && !flush && ((count_r != CW'(DEPTH)) || do_pop_s);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; left unreset because reads are masked while empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= {push_pc, push_inst};
    end
  end

  assign head_pc   = empty_s ? {XLEN{1'b0}} : mem_r[rd_ptr_r].pc;
  assign head_inst = empty_s ? {XLEN{1'b0}} : mem_r[rd_ptr_r].inst;
  assign count     = count_r;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch front end: issues sequential imem requests under a credit limit and
// queues returned {pc, inst} pairs for decode; redirects flush and drop stale responses.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(DEPTH + MAX_OUT + 1) + 1;

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] rsp_pc_r;
  logic [XLEN-1:0] target_s;
  logic [IW-1:0]   inflight_r;
  logic [IW-1:0]   drop_r;
  logic [IW-1:0]   inflight_post_rsp_s;
  logic [CW-1:0]   count_s;
  logic [SW-1:0]   occ_s;
  logic            req_valid_s;
  logic            fire_s;
  logic            rsp_s;
  logic            drop_s;
  logic            push_s;
  logic            pop_s;

  assign target_s = word_align(redirect_pc);

  // Slots already claimed: queued entries plus in-flight requests that will be kept
  assign occ_s       = SW'(count_s) + SW'(inflight_r) - SW'(drop_r);
  assign req_valid_s = rst && !redirect_valid && (inflight_r < IW'(MAX_OUT)) &&
                       (occ_s < SW'(DEPTH));
  assign fire_s      = req_valid_s && imem_req_ready;
  assign rsp_s       = imem_rsp_valid && (inflight_r != {IW{1'b0}});
  assign drop_s      = rsp_s && (drop_r != {IW{1'b0}});
  assign push_s      = rsp_s && !drop_s;
  assign pop_s       = out_valid && out_ready;

  assign inflight_post_rsp_s = inflight_r - IW'(rsp_s);

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign out_valid      = (count_s != {CW{1'b0}});

  // PC tracking, outstanding-request credit and stale-response drop count
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      inflight_r <= {IW{1'b0}};
      drop_r     <= {IW{1'b0}};
    end else begin
      inflight_r <= inflight_post_rsp_s + IW'(fire_s);
      if (redirect_valid) begin
        fetch_pc_r <= target_s;
        rsp_pc_r   <= target_s;
        drop_r     <= inflight_post_rsp_s;
      end else begin
        if (fire_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (push_s) begin
          rsp_pc_r <= rsp_pc_r + 32'd4;
        end
        if (drop_s) begin
          drop_r <= drop_r - IW'(1'b1);
        end
      end
    end
  end

  ifu_inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .push_pc  (rsp_pc_r),
    .push_inst(imem_rsp_data),
    .head_pc  (out_pc),
    .head_inst(out_inst),
    .count    (count_s)
  );

  ifu_fetch_queue_chk #(
    .IW(IW)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .imem_rsp_valid(imem_rsp_valid),
    .inflight      (inflight_r)
  );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: vector table after reset, hand-written
// flush/redirect/reset sequences, and a randomized memory with an in-order scoreboard.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  always #5 clk = ~clk;

  ifu_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        out_ready;
    logic        req_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_out_valid;
    logic [31:0] exp_out_pc;
  } vec_t;

  pend_t       pend_q[$];
  vec_t        tbl[8];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat      = 1;
  int          nvec     = 0;
  int          nfail    = 0;
  int          pop_cnt  = 0;
  logic [31:0] exp_pc   = 32'h8000_0000;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s: awaited event did not occur within its cycle budget (cycle %0d)", name, cyc);
  endtask

  // One clock: record request fires and pops, then drive next cycle's response
  task automatic tick();
    pend_t p;
    int    due;
    #1;
    if (rst && imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      p.addr = imem_req_addr;
      p.due  = due;
      pend_q.push_back(p);
      last_due = due;
    end
    if (rst && out_valid && out_ready) begin
      pop_cnt++;
      chk("sb_pc", out_pc, exp_pc);
      chk("sb_inst", out_inst, mem_f(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (rst && redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    if (!rst) begin
      pend_q.delete();
      exp_pc   = 32'h8000_0000;
      last_due = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic expect_first_pop(input string name, input logic [31:0] pc);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      #1;
      if (out_valid && out_ready) begin
        chk(name, out_pc, pc);
        found = 1'b1;
      end
      tick();
    end
    if (!found) miss(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int fires;
    int pops;
    int p0;

    // 1-cycle memory, always-ready: credit limit DEPTH=2 gives a 3-cycle rhythm
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0000_0000};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h8000_0008, 1'b1, 32'h8000_0000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b0, 32'h0000_0000};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0008};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_000C};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b0, 32'h0000_0000};

    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    out_ready      = 1'b0;
    tick();
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();

    rst = 1'b1;
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      out_ready      = tbl[i].out_ready;
      imem_req_ready = tbl[i].req_ready;
      #1;
      chk($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].exp_req_valid});
      chk($sformatf("vec%0d_req_addr", i), imem_req_addr, tbl[i].exp_req_addr);
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_out_valid});
      chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].exp_out_pc);
      if (tbl[i].exp_out_valid) chk($sformatf("vec%0d_out_inst", i), out_inst, mem_f(tbl[i].exp_out_pc));
      tick();
    end

    // Decode stalled: requests stop once the queue plus in-flight fills DEPTH
    out_ready = 1'b0;
    fires     = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_req_valid && imem_req_ready) fires++;
      tick();
    end
    chk("stall_fires_le_depth", {31'b0, fires <= 2}, 32'd1);
    #1;
    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    pops           = pop_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("stall_drain_count", pop_cnt - pops, 32'd2);

    // Two responses in flight when redirect arrives: both must be dropped
    lat            = 3;
    imem_req_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("max_out_stall", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    #1;
    chk("redir_no_issue", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_flush_empty", {31'b0, out_valid}, 32'd0);
    expect_first_pop("redir_first_pc", 32'h8000_0100);

    // Redirect coinciding with a response and a decode pop
    lat   = 1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      #1;
      if (out_valid && imem_rsp_valid) found = 1'b1;
      else tick();
    end
    if (!found) miss("coincident_setup");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coincident_flush", {31'b0, out_valid}, 32'd0);
    expect_first_pop("coincident_first_pc", 32'h8000_0200);

    // Unaligned redirect target is forced to a word boundary
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    #1;
    chk("unaligned_no_issue", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    found          = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (imem_req_valid) begin
        chk("unaligned_req_addr", imem_req_addr, 32'h8000_0100);
        found = 1'b1;
      end
      tick();
    end
    if (!found) miss("unaligned_req");
    expect_first_pop("unaligned_first_pc", 32'h8000_0100);

    // Random ready/latency with occasional redirects; scoreboard checks every pop
    p0 = pop_cnt;
    for (int i = 0; i < 1000; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = ($urandom_range(0, 3) != 0);
      lat            = 1 + int'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000 | ($urandom_range(0, 1023) << 2) | $urandom_range(0, 3);
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", {31'b0, (pop_cnt - p0) > 20}, 32'd1);

    // Reset with a full queue restarts fetch at the reset PC
    lat            = 1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("full_before_rst", {31'b0, out_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_req_low", {31'b0, imem_req_valid}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("midrst_req_addr", imem_req_addr, 32'h8000_0000);
    out_ready = 1'b1;
    expect_first_pop("midrst_first_pc", 32'h8000_0000);
    for (int i = 0; i < 20; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
